// File: rtl/interrupt_sequence_controller_if.sv
// Request/mask/INTA/EOI inputs and INT/ISR/vector outputs of the 8259-style sequencer.
// No backpressure: the CPU paces the INTA handshake, and EOI is a single-cycle strobe.
interface interrupt_sequence_controller_if;
  logic [7:0] irq_req;
  logic [7:0] irq_mask;
  logic       inta_n;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] irr_clear;
  logic [7:0] isr;
  logic [7:0] vector;
  logic       vector_valid;

  modport master (
    output irq_req, irq_mask, inta_n, eoi_valid, eoi_specific, eoi_level, vector_base,
    input  int_out, irr_clear, isr, vector, vector_valid
  );

  modport slave (
    input  irq_req, irq_mask, inta_n, eoi_valid, eoi_specific, eoi_level, vector_base,
    output int_out, irr_clear, isr, vector, vector_valid
  );
endinterface

// File: rtl/interrupt_sequence_controller.sv
// Fixed-priority nesting ISR/INTA sequencer; req->int 2 cycles, INTA edge->isr/vector 1 cycle; no backpressure.
// Define PIC_AUTO_EOI_EN to clear the serviced ISR bit automatically at the end of the second INTA pulse.
module interrupt_sequence_controller #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input logic clk,
  input logic reset,
  interrupt_sequence_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PENDING, ACK1, ACK2} state_t;

  state_t     state;
  logic       inta_prev;
  logic [7:0] elig_q;
  logic [7:0] isr_q;
  logic [7:0] irr_clear_q;
  logic [7:0] vector_q;
  logic       int_q;
  logic       vv_q;
  logic [2:0] level;
`ifdef PIC_AUTO_EOI_EN
  logic       spurious;
`endif

  logic       inta_fall;
  logic       inta_rise;
  logic [7:0] isr_low;
  logic [7:0] eligible;
  logic [7:0] ack_set;
  logic [7:0] eoi_clr;
  logic [7:0] isr_next;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) lowest = i[2:0];
  endfunction

  assign inta_fall = inta_prev & ~bus.inta_n;
  assign inta_rise = ~inta_prev & bus.inta_n;

  // isr_low - 1 selects every index below the highest in-service level; all ones when isr is empty.
  assign isr_low  = isr_q & (~isr_q + 8'd1);
  assign eligible = bus.irq_req & ~bus.irq_mask & (isr_low - 8'd1);

  always_comb begin
    ack_set = 8'd0;
    if (state == PENDING && inta_fall && elig_q != 8'd0)
      ack_set = 8'd1 << lowest(elig_q);
    eoi_clr = 8'd0;
    if (bus.eoi_valid)
      eoi_clr = bus.eoi_specific ? (8'd1 << bus.eoi_level) : isr_low;
`ifdef PIC_AUTO_EOI_EN
    if (state == ACK2 && inta_rise && !spurious)
      eoi_clr = eoi_clr | (8'd1 << level);
`endif
    // Clears act on the old isr; a same-cycle acknowledge set wins.
    isr_next = (isr_q & ~eoi_clr) | ack_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      inta_prev   <= 1'b1;
      elig_q      <= 8'd0;
      isr_q       <= 8'd0;
      irr_clear_q <= 8'd0;
      vector_q    <= 8'd0;
      int_q       <= 1'b0;
      vv_q        <= 1'b0;
      level       <= 3'd0;
`ifdef PIC_AUTO_EOI_EN
      spurious    <= 1'b0;
`endif
    end else begin
      inta_prev   <= bus.inta_n;
      elig_q      <= eligible;
      isr_q       <= isr_next;
      irr_clear_q <= ack_set;
      case (state)
        IDLE: begin
          if (elig_q != 8'd0) begin
            int_q <= 1'b1;
            state <= PENDING;
          end
        end
        PENDING: begin
          // INT stays up even if the request vanishes; the spurious level covers it.
          if (inta_fall) begin
            int_q <= 1'b0;
            state <= ACK1;
            level <= (elig_q != 8'd0) ? lowest(elig_q) : SPURIOUS_LEVEL;
`ifdef PIC_AUTO_EOI_EN
            spurious <= (elig_q == 8'd0);
`endif
          end
        end
        ACK1: begin
          if (inta_fall) begin
            vector_q <= {bus.vector_base, level};
            vv_q     <= 1'b1;
            state    <= ACK2;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            vv_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.int_out      = int_q;
  assign bus.irr_clear    = irr_clear_q;
  assign bus.isr          = isr_q;
  assign bus.vector       = vector_q;
  assign bus.vector_valid = vv_q;

endmodule
